// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel push-button conditioner.
// Each raw input passes through a 2-flop synchroniser and optional inversion.
// It is then sampled on a shared divided tick and filtered, so that the
// debounced level only flips after STABLE_SAMPLES consecutive disagreeing
// samples. Each flip of level raises a one-clock pressed or released strobe
// in the same cycle that the new level first appears.
// Optional feature: define DEBOUNCE_AUTO_REPEAT_EN to add held-key auto-repeat.
// With it, a held channel re-strobes pressed REPEAT_DELAY ticks after the
// press, and then every REPEAT_RATE ticks.
module debounce_bank #(
    parameter int CHANNELS       = 5,
    parameter int TICK_DIV       = 12500,
    parameter int STABLE_SAMPLES = 4,
    parameter bit ACTIVE_LOW     = 1'b0,
    parameter int REPEAT_DELAY   = 40,
    parameter int REPEAT_RATE    = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic                tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int STB_W = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_SAMPLES - 1);

    // Reject parameter sets the filter and repeat timing cannot honour.
    generate
        if (TICK_DIV < 1) begin : g_bad_tick_div
            $error("debounce_bank: TICK_DIV must be >= 1");
        end
        if (STABLE_SAMPLES < 1) begin : g_bad_stable
            $error("debounce_bank: STABLE_SAMPLES must be >= 1");
        end
        if (REPEAT_DELAY < 1 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_repeat
            $error("debounce_bank: need 1 <= REPEAT_RATE <= REPEAT_DELAY");
        end
    endgenerate

    // Synchroniser flops reset to the electrically inactive raw value.
    // After the polarity correction, every channel therefore reads 0 out of reset.
    localparam logic [CHANNELS-1:0] SYNC_IDLE = {CHANNELS{ACTIVE_LOW}};

    logic [CHANNELS-1:0] meta_q, meta_d;
    logic [CHANNELS-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0] sync_pol;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tick_w;
    logic [STB_W-1:0]    stb_q [CHANNELS];
    logic [STB_W-1:0]    stb_d [CHANNELS];
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] pressed_q, pressed_d;
    logic [CHANNELS-1:0] released_q, released_d;
    logic [CHANNELS-1:0] commit;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] rpt_fire;

    // Two-stage synchroniser next-state: raw into meta, meta into sync.
    always_comb begin
        meta_d = raw;
        sync_d = meta_q;
    end

    assign sync_pol = ACTIVE_LOW ? ~sync_q : sync_q;

    // Tick is decoded directly from the divider count.
    // The strobe therefore lives in exactly the cycle where the count sits at TICK_DIV-1.
    assign tick_w = (div_q == DIV_LAST);
    assign tick   = tick_w;

    // Free-running divider that wraps to 0 on the tick cycle.
    always_comb begin
        div_d = tick_w ? '0 : div_q + DIV_W'(1);
    end

    // A channel commits a new level when, on a tick, it disagrees with level
    // and its run of disagreeing samples already spans STABLE_SAMPLES-1 ticks.
    always_comb begin
        commit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            commit[i] = tick_w && (sync_pol[i] != level_q[i]) && (stb_q[i] == STB_LAST);
        end
    end

    assign rise = commit & sync_pol;
    assign fall = commit & ~sync_pol;

    // Stable counters: clear on agreement or commit, count disagreeing ticks.
    always_comb begin
        stb_d = stb_q;
        if (tick_w) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if ((sync_pol[i] == level_q[i]) || commit[i]) begin
                    stb_d[i] = '0;
                end else begin
                    stb_d[i] = stb_q[i] + STB_W'(1);
                end
            end
        end
    end

`ifdef DEBOUNCE_AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_PRE    = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [RPT_W-1:0] rpt_q [CHANNELS];
    logic [RPT_W-1:0] rpt_d [CHANNELS];

    // Repeat counters count held ticks. They fire on reaching REPEAT_DELAY,
    // then reload so that the next fire comes REPEAT_RATE ticks later.
    // A release committed on the same tick suppresses the fire.
    always_comb begin
        rpt_d    = rpt_q;
        rpt_fire = '0;
        if (tick_w) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!level_q[i] || fall[i]) begin
                    rpt_d[i] = '0;
                end else if (rpt_q[i] == RPT_PRE) begin
                    rpt_fire[i] = 1'b1;
                    rpt_d[i]    = RPT_RELOAD;
                end else begin
                    rpt_d[i] = rpt_q[i] + RPT_W'(1);
                end
            end
        end
    end

    // Repeat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                rpt_q[i] <= '0;
            end
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    assign rpt_fire = '0;
`endif

    // Output next-state: the level flips on commit.
    // The strobes mark the first cycle of the new level.
    always_comb begin
        level_d    = level_q ^ commit;
        pressed_d  = rise | rpt_fire;
        released_d = fall;
    end

    // All core state registers, cleared asynchronously.
    // Nothing survives reset, including the divider phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= SYNC_IDLE;
            sync_q     <= SYNC_IDLE;
            div_q      <= '0;
            level_q    <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                stb_q[i] <= '0;
            end
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            div_q      <= div_d;
            level_q    <= level_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            stb_q      <= stb_d;
        end
    end

    assign level    = level_q;
    assign pressed  = pressed_q;
    assign released = released_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Testbench for debounce_bank, using a small-tick configuration.
// A behavioural model tracks, for each channel, the window of samples taken
// since the last level change. It also tracks the number of ticks held since
// the press. Every cycle, the DUT outputs are compared against that model.
module tb_debounce_bank;
    localparam int CH = 5;
    localparam int TD = 4;
    localparam int SS = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] raw   = '0;
    logic [CH-1:0] level, pressed, released;
    logic          tick;

    int total = 0;
    int bad   = 0;

    logic [3*CH:0] got_v, exp_v;

    debounce_bank #(
        .CHANNELS(CH), .TICK_DIV(TD), .STABLE_SAMPLES(SS), .ACTIVE_LOW(1'b0),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .raw(raw),
        .level(level), .pressed(pressed), .released(released), .tick(tick)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [CH-1:0] m_s1 = '0, m_s2 = '0;
    logic [CH-1:0] m_level = '0, m_pressed = '0, m_released = '0;
    int            m_div = 0;
    logic [SS-1:0] m_win   [CH];
    int            m_nsamp [CH];
    int            m_held  [CH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_pressed = '0; m_released = '0; m_div = 0;
            for (int c = 0; c < CH; c++) begin
                m_win[c] = '0; m_nsamp[c] = 0; m_held[c] = 0;
            end
        end else begin
            m_pressed  = '0;
            m_released = '0;
            if (m_div == TD - 1) begin
                for (int c = 0; c < CH; c++) begin
                    m_win[c]   = {m_win[c][SS-2:0], m_s2[c]};
                    m_nsamp[c] = m_nsamp[c] + 1;
                    if (m_nsamp[c] >= SS && m_win[c] == {SS{~m_level[c]}}) begin
                        m_level[c] = ~m_level[c];
                        m_nsamp[c] = 0;
                        if (m_level[c]) begin
                            m_pressed[c] = 1'b1;
                            m_held[c]    = 0;
                        end else begin
                            m_released[c] = 1'b1;
                        end
                    end else if (m_level[c]) begin
                        m_held[c] = m_held[c] + 1;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                        if (m_held[c] >= RD && ((m_held[c] - RD) % RR) == 0) m_pressed[c] = 1'b1;
`endif
                    end
                end
                m_div = 0;
            end else begin
                m_div = m_div + 1;
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    end

    // ---------------- scenario tasks ----------------
    task automatic test_reset;
        int n_tick;
        int last;
        int first;
        rst_n = 1'b0;
        raw   = '1;
        repeat (4) @(negedge clk);
        total++;
        if ({level, pressed, released, tick} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0", {level, pressed, released, tick});
        end
        raw = '0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        n_tick = 0;
        last   = -1;
        first  = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (tick) begin
                if (first < 0) first = i;
                if (last >= 0) begin
                    total++;
                    if (i - last != TD) begin
                        bad++;
                        $display("FAIL tick_period got=%0d exp=%0d", i - last, TD);
                    end
                end
                last = i;
                n_tick++;
            end
        end
        total++;
        if (first != TD - 1) begin
            bad++;
            $display("FAIL tick_first got=%0d exp=%0d", first, TD - 1);
        end
        total++;
        if (n_tick != 16 / TD) begin
            bad++;
            $display("FAIL tick_count got=%0d exp=%0d", n_tick, 16 / TD);
        end
    endtask

    task automatic test_clean_press;
        int rise_at;
        int n_press;
        int n_rel;
        int others;
        rise_at = -1; n_press = 0; n_rel = 0; others = 0;
        raw[0] = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            got_v = {level, pressed, released, tick};
            exp_v = {m_level, m_pressed, m_released, m_div == TD - 1};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL clean_press cyc=%0d got=%b exp=%b", i, got_v, exp_v);
            end
            if (level[0] && rise_at < 0) rise_at = i;
            if (pressed[0]) n_press++;
            if (level[CH-1:1] != '0 || pressed[CH-1:1] != '0) others++;
        end
        total++;
        if (rise_at < 1 || rise_at > 4 * TD) begin
            bad++;
            $display("FAIL press_latency got=%0d exp=1..%0d", rise_at, 4 * TD);
        end
        total++;
        if (n_press != 1) begin
            bad++;
            $display("FAIL press_strobe_count got=%0d exp=1", n_press);
        end
        total++;
        if (others != 0) begin
            bad++;
            $display("FAIL press_other_channels got=%0d exp=0", others);
        end
        raw[0] = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (released[0]) n_rel++;
        end
        total++;
        if (n_rel != 1 || level[0] !== 1'b0) begin
            bad++;
            $display("FAIL clean_release got=%0d/%b exp=1/0", n_rel, level[0]);
        end
    endtask

    task automatic test_glitch;
        int seen;
        seen = 0;
        raw[1] = 1'b1;
        for (int i = 1; i <= 38; i++) begin
            if (i == 9) raw[1] = 1'b0;
            @(negedge clk);
            got_v = {level, pressed, released, tick};
            exp_v = {m_level, m_pressed, m_released, m_div == TD - 1};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL glitch cyc=%0d got=%b exp=%b", i, got_v, exp_v);
            end
            if (level[1] || pressed[1] || released[1]) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL glitch_reject got=%0d exp=0", seen);
        end
    endtask

    task automatic test_release_simul;
        int at2;
        int at3;
        int n2;
        int n3;
        at2 = -1; at3 = -2; n2 = 0; n3 = 0;
        raw[3:2] = 2'b11;
        repeat (30) @(negedge clk);
        total++;
        if (level[3:2] !== 2'b11) begin
            bad++;
            $display("FAIL simul_hold got=%b exp=11", level[3:2]);
        end
        raw[3:2] = 2'b00;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            got_v = {level, pressed, released, tick};
            exp_v = {m_level, m_pressed, m_released, m_div == TD - 1};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL simul_release cyc=%0d got=%b exp=%b", i, got_v, exp_v);
            end
            if (released[2]) begin n2++; at2 = i; end
            if (released[3]) begin n3++; at3 = i; end
        end
        total++;
        if (n2 != 1 || n3 != 1 || at2 != at3) begin
            bad++;
            $display("FAIL simul_strobes got=n2:%0d n3:%0d at2:%0d at3:%0d exp=1 1 equal", n2, n3, at2, at3);
        end
    endtask

    task automatic test_auto_repeat;
        int n_press;
        int ticks_since;
        int exp_n;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
        exp_n = 28;
`else
        exp_n = 1;
`endif
        n_press = 0; ticks_since = 0;
        // Raw is held 58 ticks, so the level stays up for 58 ticks after the press commits.
        raw[4] = 1'b1;
        for (int i = 1; i <= 58 * TD + 30; i++) begin
            if (i == 58 * TD + 1) raw[4] = 1'b0;
            @(negedge clk);
            got_v = {level, pressed, released, tick};
            exp_v = {m_level, m_pressed, m_released, m_div == TD - 1};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL auto_repeat cyc=%0d got=%b exp=%b", i, got_v, exp_v);
            end
            if (pressed[4]) begin
                n_press++;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
                if (n_press == 2 || n_press == 3) begin
                    total++;
                    if (ticks_since != (n_press == 2 ? RD : RR)) begin
                        bad++;
                        $display("FAIL repeat_gap n=%0d got=%0d exp=%0d", n_press, ticks_since,
                                 (n_press == 2 ? RD : RR));
                    end
                end
`endif
                ticks_since = 0;
            end
            if (tick) ticks_since++;
        end
        total++;
        if (n_press != exp_n) begin
            bad++;
            $display("FAIL repeat_count got=%0d exp=%0d", n_press, exp_n);
        end
    endtask

    task automatic test_reset_mid_press;
        int up;
        int press_at;
        int n_press;
        int n_rel;
        up = 0; press_at = -1; n_press = 0; n_rel = 0;
        raw[0] = 1'b1;
        for (int i = 1; i <= 40 && up == 0; i++) begin
            @(negedge clk);
            if (level[0]) up = 1;
        end
        total++;
        if (up == 0) begin
            bad++;
            $display("FAIL midreset_setup got=level0:%b exp=1", level[0]);
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (level[0] !== 1'b0 || released !== '0 || pressed !== '0) begin
            bad++;
            $display("FAIL midreset_async got=%b/%b/%b exp=0/0/0", level[0], released, pressed);
        end
        #28 rst_n = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            got_v = {level, pressed, released, tick};
            exp_v = {m_level, m_pressed, m_released, m_div == TD - 1};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL midreset_run cyc=%0d got=%b exp=%b", i, got_v, exp_v);
            end
            if (pressed[0]) begin n_press++; press_at = i; end
            if (released[0]) n_rel++;
        end
        total++;
        if (n_press != 1 || press_at != SS * TD || n_rel != 0) begin
            bad++;
            $display("FAIL midreset_repress got=n:%0d at:%0d rel:%0d exp=1 %0d 0", n_press, press_at, n_rel, SS * TD);
        end
        raw[0] = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_random;
        int hold;
        int cyc;
        cyc = 0;
        while (cyc < 800) begin
            raw  = CH'($urandom);
            hold = $urandom_range(1, 20);
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                cyc++;
                got_v = {level, pressed, released, tick};
                exp_v = {m_level, m_pressed, m_released, m_div == TD - 1};
                total++;
                if (got_v !== exp_v) begin
                    bad++;
                    $display("FAIL random cyc=%0d got=%b exp=%b", cyc, got_v, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_glitch;
        test_release_simul;
        test_auto_repeat;
        test_reset_mid_press;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
